// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one bank of JK flip-flops between several requesters.
// Each granted op drives J/K for one cycle, then the bank's Q is compared against the expected result.
module jk_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   mask,
    input  logic [WIDTH-1:0]        q_in,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        j_out,
    output logic [WIDTH-1:0]        k_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  j_q;
    logic [WIDTH-1:0]  k_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  exp_q;

    logic              found_d;
    logic [NREQ-1:0]   gnt_d;
    logic [PW-1:0]     ptr_d;
    logic [1:0]        op_sel_d;
    logic [WIDTH-1:0]  mask_sel_d;

    // Bank value a correct JK bank holds one edge after {J,K}=op is applied to the masked bits.
    function automatic logic [WIDTH-1:0] jk_expect(input logic [1:0] op_f,
                                                   input logic [WIDTH-1:0] mask_f,
                                                   input logic [WIDTH-1:0] q_f);
        logic [WIDTH-1:0] res;
        res = q_f;
        for (int b = 0; b < WIDTH; b++) begin
            if (mask_f[b]) begin
                case (op_f)
                    2'b00:   res[b] = q_f[b];
                    2'b01:   res[b] = 1'b0;
                    2'b10:   res[b] = 1'b1;
                    2'b11:   res[b] = ~q_f[b];
                    default: res[b] = q_f[b];
                endcase
            end else begin
                res[b] = q_f[b];
            end
        end
        return res;
    endfunction

    // Round-robin pick: first requesting index scanning upward from the pointer, wrapping.
    always_comb begin
        int idx_v;
        found_d    = 1'b0;
        gnt_d      = '0;
        ptr_d      = ptr_q;
        op_sel_d   = 2'b00;
        mask_sel_d = '0;
        idx_v      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(ptr_q) + k) % NREQ;
            if (!found_d && req[idx_v]) begin
                found_d       = 1'b1;
                gnt_d[idx_v]  = 1'b1;
                op_sel_d      = op[2*idx_v +: 2];
                mask_sel_d    = mask[WIDTH*idx_v +: WIDTH];
                ptr_d         = (idx_v == NREQ - 1) ? '0 : PW'(idx_v + 1);
            end else begin
                idx_v = idx_v;
            end
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= 2'b00;
            mask_q  <= '0;
            exp_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (found_d) begin
                        state_q <= ST_APPLY;
                        ptr_q   <= ptr_d;
                        gnt_q   <= gnt_d;
                        op_q    <= op_sel_d;
                        mask_q  <= mask_sel_d;
                        j_q     <= mask_sel_d & {WIDTH{op_sel_d[1]}};
                        k_q     <= mask_sel_d & {WIDTH{op_sel_d[0]}};
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= '0;
                        j_q    <= '0;
                        k_q    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    // q_in is still the pre-op value here; the bank updates on this same edge.
                    exp_q   <= jk_expect(op_q, mask_q, q_in);
                    gnt_q   <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    done_q  <= 1'b1;
                    err_q   <= (q_in != exp_q);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign j_out = j_q;
    assign k_out = k_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed plus randomized bench for jk_bank_sched with a JK bank model and an arithmetic reference model.
module tb_jk_bank_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_r;
    logic [2*NREQ-1:0]     op_bus;
    logic [WIDTH*NREQ-1:0] mask_bus;
    logic [WIDTH-1:0]      q_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      j_out;
    logic [WIDTH-1:0]      k_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic [1:0]            op_v   [NREQ];
    logic [WIDTH-1:0]      mask_v [NREQ];
    logic [WIDTH-1:0]      bank_q;
    logic                  load_en;
    logic [WIDTH-1:0]      load_val;
    logic                  corrupt_r;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;
    logic [WIDTH-1:0] model_q;

    jk_bank_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_r),
        .op    (op_bus),
        .mask  (mask_bus),
        .q_in  (q_in),
        .gnt   (gnt),
        .j_out (j_out),
        .k_out (k_out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        op_bus   = '0;
        mask_bus = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_bus[2*i +: 2]           = op_v[i];
            mask_bus[WIDTH*i +: WIDTH] = mask_v[i];
        end
    end

    // JK bank: J alone sets, K alone clears, both toggle.
    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else         bank_q <= (bank_q & ~k_out) | (~bank_q & j_out);
    end

    assign q_in = corrupt_r ? 8'h00 : bank_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_v[i]   = 2'($urandom_range(0, 3));
            mask_v[i] = 8'($urandom);
        end
    endtask

    // One full arbitrated operation, starting at a negedge with the DUT idle.
    task automatic run_txn(input bit drop, input bit corrupt, input bit scramble);
        int w;
        int lat;
        logic [1:0]       o;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] qn;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_r[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
        end
        if (w < 0) begin
            check("model_has_request", 32'd0, 32'd1);
            return;
        end
        o = op_v[w];
        m = mask_v[w];
        case (o)
            2'b00:   qn = model_q;
            2'b01:   qn = model_q & ~m;
            2'b10:   qn = model_q | m;
            default: qn = model_q ^ m;
        endcase
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 6);
        check("gnt_latency", 32'(lat), 32'd1);
        if (gnt == '0) return;
        check("gnt", 32'(gnt), 32'(1 << w));
        check("j_apply", 32'(j_out), 32'(o[1] ? m : 8'h00));
        check("k_apply", 32'(k_out), 32'(o[0] ? m : 8'h00));
        check("busy_apply", 32'(busy), 32'd1);
        check("done_apply", 32'(done), 32'd0);
        mptr = (w + 1) % NREQ;
        if (drop)     req_r[w] = 1'b0;
        if (corrupt)  corrupt_r = 1'b1;
        if (scramble) randomize_ops();
        @(negedge clk);
        check("gnt_check", 32'(gnt), 32'd0);
        check("jk_check", 32'({j_out, k_out}), 32'd0);
        check("busy_check", 32'(busy), 32'd1);
        check("done_check", 32'(done), 32'd0);
        if (!corrupt) check("q_after", 32'(q_in), 32'(qn));
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("err", 32'(err), 32'(corrupt));
        check("busy_done", 32'(busy), 32'd0);
        check("gnt_done", 32'(gnt), 32'd0);
        check("jk_done", 32'({j_out, k_out}), 32'd0);
        model_q   = qn;
        corrupt_r = 1'b0;
    endtask

    task automatic load_bank(input logic [WIDTH-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
        model_q  = v;
    endtask

    initial begin
        int dcount;
        rst_n     = 1'b0;
        req_r     = 4'b1111;
        corrupt_r = 1'b0;
        load_en   = 1'b1;
        load_val  = 8'h00;
        model_q   = 8'h00;
        randomize_ops();
        op_v[0]   = 2'b10;
        mask_v[0] = 8'h0F;

        // Reset held two cycles with all requests high.
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_jk", 32'({j_out, k_out}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        load_en = 1'b0;
        rst_n   = 1'b1;

        // Requests held high: grants rotate 0,1,2,3,0 three cycles apart; first is the set op on 8'h0F.
        for (int n = 0; n < 5; n++) run_txn(1'b0, 1'b0, 1'b0);
        req_r = '0;

        // Toggle all bits of 8'hA5 from requester 2.
        load_bank(8'hA5);
        op_v[2] = 2'b11; mask_v[2] = 8'hFF; req_r = 4'b0100;
        run_txn(1'b1, 1'b0, 1'b0);
        check("toggle_result", 32'(q_in), 32'h5A);

        // Empty mask is still granted and completes cleanly.
        op_v[1] = 2'b10; mask_v[1] = 8'h00; req_r = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0);

        // Bank reads back 0 after a set of bit 0: readback error.
        load_bank(8'h00);
        op_v[3] = 2'b10; mask_v[3] = 8'h01; req_r = 4'b1000;
        run_txn(1'b1, 1'b1, 1'b0);

        // Random request mixes; op/mask scrambled while the op is in flight.
        for (int it = 0; it < 30; it++) begin
            logic [NREQ-1:0] add;
            add = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (add[i] && !req_r[i]) begin
                    op_v[i]   = 2'($urandom_range(0, 3));
                    mask_v[i] = 8'($urandom);
                end
            end
            req_r = req_r | add;
            run_txn(1'b1, 1'b0, 1'b1);
        end
        req_r = '0;
        @(negedge clk);

        // Reset during APPLY aborts the op.
        op_v[0] = 2'b10; mask_v[0] = 8'hFF; req_r = 4'b0001;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'd1);
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req_r = '0;
        @(negedge clk);
        check("abort_jk", 32'({j_out, k_out}), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_gnt_low", 32'(gnt), 32'd0);
        model_q = model_q | 8'hFF;
        mptr    = 0;
        rst_n   = 1'b1;
        dcount  = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_bank_kept", 32'(q_in), 32'(model_q));

        // Pointer restarts at 0 after reset.
        req_r = 4'b1010;
        run_txn(1'b1, 1'b0, 1'b0);
        req_r = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
